// File: rtl/fill_row_writer.sv
// -----------------------------------------------------------------------------
// fill_row_writer
//
// Purpose:
//   Downstream stage of the fill controller. On fill_start it writes one
//   horizontal span of pixels (x_left..x_right inclusive, on row_y) in
//   fill_color into the frame buffer through a req/ack write port. It pulses
//   fill_done when the span is complete so the controller can advance to the
//   next row.
//
// Handshake (fb write port):
//   fb_wr_req is held high for as long as a pixel is pending. fb_addr and
//   fb_wdata are stable while fb_wr_req is high and fb_wr_ack is low. A pixel
//   transfers on every rising clk edge where fb_wr_req and fb_wr_ack are both
//   high. fb_wr_ack is ignored while fb_wr_req is low.
//
// Ports:
//   clk, n_rst   clock, asynchronous active-low reset
//   fill_start   one-cycle start pulse (ignored unless idle)
//   x_left       first pixel of span (inclusive)
//   x_right      last pixel of span (inclusive)
//   row_y        row index
//   fill_color   pixel value to write
//   fb_wr_req    write request
//   fb_addr      write address, row_y*SCREEN_W + x
//   fb_wdata     write data
//   fb_wr_ack    write accepted this cycle
//   fill_done    one-cycle pulse when the span has finished
//   busy         high whenever the FSM is not idle
//   pix_count    pixels written in the current/last span
//
// Configuration:
//   FILL_CLIP_EN  when defined, the span is clipped to the visible screen:
//                 x_right clamps to SCREEN_W-1, and the span is empty if
//                 row_y >= SCREEN_H or x_left >= SCREEN_W. When undefined,
//                 coordinates are used raw.
// -----------------------------------------------------------------------------
module fill_row_writer #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int COLOR_W  = 24,
  parameter int ADDR_W   = 19
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               fill_start,
  input  logic [X_W-1:0]     x_left,
  input  logic [X_W-1:0]     x_right,
  input  logic [Y_W-1:0]     row_y,
  input  logic [COLOR_W-1:0] fill_color,
  output logic               fb_wr_req,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_wdata,
  input  logic               fb_wr_ack,
  output logic               fill_done,
  output logic               busy,
  output logic [X_W:0]       pix_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [X_W-1:0]     xl_q;
  logic [X_W-1:0]     xr_q;
  logic [X_W-1:0]     x_cur;
  logic [Y_W-1:0]     y_q;
  logic [COLOR_W-1:0] color_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [X_W:0]       pix_q;

  logic [ADDR_W-1:0]  setup_addr;
  logic [X_W-1:0]     xr_eff;
  logic               span_empty;
  logic               last_pix;

  // Truncation to ADDR_W at each operand keeps the result equal to the full
  // product modulo 2^ADDR_W, so no wider intermediate is needed.
  assign setup_addr = ADDR_W'(y_q) * ADDR_W'(SCREEN_W) + ADDR_W'(xl_q);

`ifdef FILL_CLIP_EN
  localparam logic [X_W:0] W_LIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] H_LIM = (Y_W+1)'(SCREEN_H);

  always_comb begin
    xr_eff = xr_q;
    if ({1'b0, xr_q} >= W_LIM) begin
      xr_eff = X_W'(SCREEN_W - 1);
    end
    span_empty = ({1'b0, y_q} >= H_LIM) || ({1'b0, xl_q} >= W_LIM) ||
                 (xl_q > xr_eff);
  end
`else
  assign xr_eff     = xr_q;
  assign span_empty = (xl_q > xr_q);
`endif

  // Compare before increment: x_right at the top of the coordinate range
  // terminates the span without x_cur ever wrapping.
  assign last_pix = (x_cur == xr_q);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    fb_wr_req = 1'b0;
    fill_done = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (fill_start) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = span_empty ? DONE : WRITE;
      end
      WRITE: begin
        fb_wr_req = 1'b1;
        if (fb_wr_ack && last_pix) begin
          state_d = DONE;
        end
      end
      DONE: begin
        fill_done = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: latched span, pixel cursor, address and count
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      xl_q    <= '0;
      xr_q    <= '0;
      x_cur   <= '0;
      y_q     <= '0;
      color_q <= '0;
      addr_q  <= '0;
      pix_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fill_start) begin
            xl_q    <= x_left;
            xr_q    <= x_right;
            y_q     <= row_y;
            color_q <= fill_color;
            pix_q   <= '0;
          end
        end
        SETUP: begin
          addr_q <= setup_addr;
          x_cur  <= xl_q;
          xr_q   <= xr_eff;
        end
        WRITE: begin
          if (fb_wr_ack) begin
            pix_q <= pix_q + 1'b1;
            if (!last_pix) begin
              x_cur  <= x_cur + 1'b1;
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fb_addr   = addr_q;
  assign fb_wdata  = color_q;
  assign pix_count = pix_q;

endmodule

// File: tb/tb_fill_row_writer.sv
// -----------------------------------------------------------------------------
// tb_fill_row_writer
//
// Bench for fill_row_writer. A reference model derives, from the span
// coordinates alone, the list of (address, data) writes and the pixel count;
// the expected writes sit in exp_q and a negedge monitor consumes them as the
// DUT presents writes. Directed cases plus randomized spans and ack patterns.
// -----------------------------------------------------------------------------
module tb_fill_row_writer;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int COLOR_W  = 24;
  localparam int ADDR_W   = 19;
  localparam int W        = ADDR_W + COLOR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic               fill_start;
  logic [X_W-1:0]     x_left;
  logic [X_W-1:0]     x_right;
  logic [Y_W-1:0]     row_y;
  logic [COLOR_W-1:0] fill_color;
  logic               fb_wr_req;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_wdata;
  logic               fb_wr_ack;
  logic               fill_done;
  logic               busy;
  logic [X_W:0]       pix_count;

  fill_row_writer #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .X_W      (X_W),
    .Y_W      (Y_W),
    .COLOR_W  (COLOR_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .fill_start (fill_start),
    .x_left     (x_left),
    .x_right    (x_right),
    .row_y      (row_y),
    .fill_color (fill_color),
    .fb_wr_req  (fb_wr_req),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .fb_wr_ack  (fb_wr_ack),
    .fill_done  (fill_done),
    .busy       (busy),
    .pix_count  (pix_count)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (n_rst) begin
      if (fill_done) done_cnt++;
      if (fb_wr_req) begin
        check("wr_req_expected", 64'(fb_wr_req), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          check("wr_addr", 64'(fb_addr), 64'(exp_q[0][W-1:COLOR_W]));
          check("wr_data", 64'(fb_wdata), 64'(exp_q[0][COLOR_W-1:0]));
          if (fb_wr_ack) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- ack driver ----------------
  // mode 0: always high, 1: every 3rd cycle, 2: random
  int ack_mode = 0;
  int ack_ctr  = 0;
  always @(posedge clk) begin
    #1;
    ack_ctr++;
    case (ack_mode)
      0:       fb_wr_ack = 1'b1;
      1:       fb_wr_ack = ((ack_ctr % 3) == 0);
      default: fb_wr_ack = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- reference model ----------------
  // Returns the inclusive pixel range actually written; empty=1 means none.
  task automatic model_span(input int xl, input int xr, input int y,
                            output int lo, output int hi, output bit empty);
    lo = xl;
    hi = xr;
`ifdef FILL_CLIP_EN
    if (hi > SCREEN_W - 1) hi = SCREEN_W - 1;
    empty = (y >= SCREEN_H) || (xl >= SCREEN_W) || (lo > hi);
`else
    empty = (lo > hi);
`endif
  endtask

  task automatic push_expected(input int lo, input int hi, input bit empty,
                               input int y, input logic [COLOR_W-1:0] col);
    if (!empty) begin
      for (int x = lo; x <= hi; x++) begin
        exp_q.push_back({ADDR_W'(y * SCREEN_W + x), col});
      end
    end
  endtask

  task automatic scramble_inputs();
    x_left     = X_W'($urandom);
    x_right    = X_W'($urandom);
    row_y      = Y_W'($urandom);
    fill_color = COLOR_W'($urandom);
  endtask

  // ---------------- span driver ----------------
  task automatic run_span(input int xl, input int xr, input int y,
                          input logic [COLOR_W-1:0] col, input int mode,
                          input bit glitch);
    int lo, hi, n, budget, base_done, done_cyc, req_cycles;
    bit empty, seen;
    model_span(xl, xr, y, lo, hi, empty);
    n = empty ? 0 : (hi - lo + 1);
    push_expected(lo, hi, empty, y, col);
    ack_mode  = mode;
    base_done = done_cnt;
    budget    = 20 * n + 20;

    @(posedge clk); #1;
    fill_start = 1'b1;
    x_left     = X_W'(xl);
    x_right    = X_W'(xr);
    row_y      = Y_W'(y);
    fill_color = col;
    @(posedge clk); #1;            // edge 0 has sampled fill_start
    fill_start = 1'b0;
    scramble_inputs();             // span must come from latched values

    seen = 0; done_cyc = 0; req_cycles = 0;
    for (int cyc = 1; cyc <= budget && !seen; cyc++) begin
      @(negedge clk); #1;
      if (cyc == 1) check("busy_setup", 64'(busy), 64'(1));
      if (fb_wr_req) req_cycles++;
      if (fill_done) begin
        seen = 1;
        done_cyc = cyc;
      end
      if (glitch && cyc == 3) begin
        fill_start = 1'b1;
        scramble_inputs();
      end else begin
        fill_start = 1'b0;
      end
    end
    fill_start = 1'b0;

    check("done_seen", 64'(seen), 64'(1));
    if (seen) begin
      if (mode == 0) begin
        check("done_latency", 64'(done_cyc), 64'(n + 2));
        check("req_cycles", 64'(req_cycles), 64'(n));
      end
      check("pix_count", 64'(pix_count), 64'(n));
      check("writes_left", 64'(exp_q.size()), 64'(0));
      @(negedge clk); #1;
      check("done_width", 64'(fill_done), 64'(0));
      check("busy_after", 64'(busy), 64'(0));
      check("pix_hold", 64'(pix_count), 64'(n));
      check("done_count", 64'(done_cnt - base_done), 64'(1));
    end
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_done;
    n_rst      = 1'b0;
    fill_start = 1'b0;
    x_left     = '0;
    x_right    = '0;
    row_y      = '0;
    fill_color = '0;
    fb_wr_ack  = 1'b0;

    #22;
    check("rst_req", 64'(fb_wr_req), 64'(0));
    check("rst_addr", 64'(fb_addr), 64'(0));
    check("rst_data", 64'(fb_wdata), 64'(0));
    check("rst_done", 64'(fill_done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pix", 64'(pix_count), 64'(0));
    @(negedge clk);
    n_rst = 1'b1;

    // Basic span, ack tied high: addr 1290..1293, done in cycle 6
    run_span(10, 13, 2, 24'hFF0000, 0, 0);
    // Ack every third cycle, span 0..1 row 0
    run_span(0, 1, 0, 24'h00A5C3, 1, 0);
    // Empty span
    run_span(20, 5, 7, 24'h123456, 0, 0);
    // Single pixel
    run_span(300, 300, 100, 24'hABCDEF, 0, 0);
    // Restart pulse mid-span is ignored
    run_span(40, 60, 11, 24'h0F0F0F, 0, 1);
    run_span(40, 60, 12, 24'hF0F0F0, 2, 1);
    // Top of coordinate range: x_cur must not wrap
    run_span(1020, 1023, 3, 24'h777777, 0, 0);
    run_span(1023, 1023, 4, 24'h888888, 2, 0);

    // Reset during WRITE of span 100..200
    ack_mode = 0;
    push_expected(100, 200, 0, 5, 24'h5A5A5A);
    @(posedge clk); #1;
    fill_start = 1'b1;
    x_left = 10'd100; x_right = 10'd200; row_y = 9'd5; fill_color = 24'h5A5A5A;
    @(posedge clk); #1;
    fill_start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("midspan_busy", 64'(busy), 64'(1));
    n_rst = 1'b0;
    #1;
    check("abort_req", 64'(fb_wr_req), 64'(0));
    check("abort_addr", 64'(fb_addr), 64'(0));
    check("abort_data", 64'(fb_wdata), 64'(0));
    check("abort_done", 64'(fill_done), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_pix", 64'(pix_count), 64'(0));
    exp_q.delete();
    base_done = done_cnt;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - base_done), 64'(0));
    check("abort_idle", 64'(busy), 64'(0));
    run_span(100, 110, 5, 24'h5A5A5A, 0, 0);

`ifdef FILL_CLIP_EN
    run_span(630, 700, 479, 24'h00FF00, 0, 0);
    run_span(10, 20, 480, 24'h0000FF, 0, 0);
    run_span(700, 710, 10, 24'h0000FF, 0, 0);
`endif

    // Randomized spans and ack patterns
    for (int i = 0; i < 25; i++) begin
      int xl, xr, y, len;
      y   = $urandom_range(0, SCREEN_H - 1);
      xl  = $urandom_range(0, SCREEN_W - 1);
      len = $urandom_range(0, 32);
      xr  = xl + len - 2;
      if (xr < 0) xr = 0;
      if (xr > SCREEN_W - 1) xr = SCREEN_W - 1;
      run_span(xl, xr, y, COLOR_W'($urandom), $urandom_range(0, 2),
               1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
